// File: rtl/ahb_lite_cmd_master.sv
// rtl/ahb_lite_cmd_master.sv - single-transfer AHB-Lite initiator fed by a command/response port
// Address-phase and data-phase registers give one NONSEQ/SINGLE transfer per cycle.
module ahb_lite_cmd_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA
);

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_NONSEQ = 2'b10
  } htrans_e;

  htrans_e               htrans_q, htrans_d;
  logic                  ap_valid_q, ap_valid_d;
  logic [ADDR_WIDTH-1:0] ap_addr_q, ap_addr_d;
  logic                  ap_write_q, ap_write_d;
  logic [2:0]            ap_size_q, ap_size_d;
  logic [DATA_WIDTH-1:0] ap_wdata_q, ap_wdata_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic [DATA_WIDTH-1:0] dp_wdata_q, dp_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

  logic err1, ap_issue, dp_done, cmd_accept;

  assign err1       = dp_valid_q & ~HREADY & (HRESP != 2'b00);
  assign ap_issue   = HREADY & ap_valid_q & (htrans_q == HT_NONSEQ);
  assign dp_done    = HREADY & dp_valid_q;
  assign cmd_ready  = ~ap_valid_q | (HREADY & (htrans_q == HT_NONSEQ) & ~err1);
  assign cmd_accept = cmd_valid & cmd_ready;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      htrans_q    <= HT_IDLE;
      ap_valid_q  <= 1'b0;
      ap_addr_q   <= '0;
      ap_write_q  <= 1'b0;
      ap_size_q   <= 3'b000;
      ap_wdata_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      htrans_q    <= htrans_d;
      ap_valid_q  <= ap_valid_d;
      ap_addr_q   <= ap_addr_d;
      ap_write_q  <= ap_write_d;
      ap_size_q   <= ap_size_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  always_comb begin
    htrans_d    = htrans_q;
    ap_valid_d  = ap_valid_q;
    ap_addr_d   = ap_addr_q;
    ap_write_d  = ap_write_q;
    ap_size_d   = ap_size_q;
    ap_wdata_d  = ap_wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    // A command loaded during the first error cycle must still show IDLE in the second.
    if (cmd_accept) begin
      ap_valid_d = 1'b1;
      ap_addr_d  = cmd_addr;
      ap_write_d = cmd_write;
      ap_size_d  = cmd_size;
      ap_wdata_d = cmd_wdata;
      htrans_d   = err1 ? HT_IDLE : HT_NONSEQ;
    end else if (ap_issue) begin
      ap_valid_d = 1'b0;
      htrans_d   = HT_IDLE;
    end else if (err1) begin
      htrans_d   = HT_IDLE;
    end else if (HREADY && ap_valid_q && htrans_q == HT_IDLE) begin
      htrans_d   = HT_NONSEQ;
    end

    if (ap_issue) begin
      dp_valid_d = 1'b1;
      dp_write_d = ap_write_q;
      dp_wdata_d = ap_wdata_q;
    end else if (dp_done) begin
      dp_valid_d = 1'b0;
    end

    if (dp_done) begin
      rsp_valid_d = 1'b1;
      rsp_error_d = (HRESP != 2'b00);
      rsp_rdata_d = dp_write_q ? '0 : HRDATA;
    end
  end

  assign HTRANS    = ap_valid_q ? htrans_q : HT_IDLE;
  assign HADDR     = ap_addr_q;
  assign HWRITE    = ap_write_q;
  assign HSIZE     = ap_size_q;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HWDATA    = dp_valid_q ? dp_wdata_q : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// tb/tb_ahb_lite_cmd_master.sv - directed self-checking bench for ahb_lite_cmd_master
module tb_ahb_lite_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [1:0]  er;

  ahb_lite_cmd_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic e);
    rsp_t r;
    r.rdata = d;
    r.err   = e;
    exp_q.push_back(r);
  endtask

  // Advance one cycle and score any response the DUT produced.
  task automatic tick();
    rsp_t r;
    @(posedge HCLK);
    #1;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_spurious", rsp_valid, 1'b0);
      end else begin
        r = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, r.rdata);
        chk("rsp_error", rsp_error, r.err);
      end
    end
  endtask

  task automatic drive_cmd(input logic v, input logic [31:0] a, input logic w,
                           input logic [2:0] s, input logic [31:0] d);
    cmd_valid = v;
    cmd_addr  = a;
    cmd_write = w;
    cmd_size  = s;
    cmd_wdata = d;
  endtask

  initial begin
    HRESETn = 1'b0;
    HREADY  = 1'b1;
    HRESP   = 2'b00;
    HRDATA  = 32'h0;
    drive_cmd(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    #3;
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", HWRITE, 1'b0);
    chk("rst_hsize", HSIZE, 3'd0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_hburst", HBURST, 3'b000);
    chk("rst_hprot", HPROT, 4'b0011);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_error", rsp_error, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    tick();
    tick();
    HRESETn = 1'b1;

    // Single read, zero-wait slave
    drive_cmd(1'b1, 32'h2000_0010, 1'b0, 3'd2, 32'h0);
    push_exp(32'hCAFE_F00D, 1'b0);
    #1 chk("rd_cmd_ready", cmd_ready, 1'b1);
    tick();
    drive_cmd(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    #1;
    chk("rd_htrans", HTRANS, 2'b10);
    chk("rd_haddr", HADDR, 32'h2000_0010);
    chk("rd_hsize", HSIZE, 3'd2);
    chk("rd_hwrite", HWRITE, 1'b0);
    tick();
    HRDATA = 32'hCAFE_F00D;
    #1;
    chk("rd_dp_htrans", HTRANS, 2'b00);
    chk("rd_rsp_early", rsp_valid, 1'b0);
    tick();
    #1 chk("rd_rsp_valid", rsp_valid, 1'b1);

    // Four back-to-back writes
    for (int i = 0; i < 7; i++) begin
      tick();
      HRDATA = 32'hDEAD_BEEF;
      if (i < 4) begin
        drive_cmd(1'b1, 32'(4 * i), 1'b1, 3'd2, 32'(i + 1));
        push_exp(32'h0, 1'b0);
      end else begin
        drive_cmd(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
      end
      #1;
      if (i < 4) chk("b2b_cmd_ready", cmd_ready, 1'b1);
      if (i >= 1 && i <= 4) begin
        chk("b2b_htrans", HTRANS, 2'b10);
        chk("b2b_haddr", HADDR, 32'(4 * (i - 1)));
        chk("b2b_hwrite", HWRITE, 1'b1);
      end else begin
        chk("b2b_htrans_idle", HTRANS, 2'b00);
      end
      if (i >= 2 && i <= 5) chk("b2b_hwdata", HWDATA, 32'(i - 1));
      chk("b2b_rsp_valid", rsp_valid, (i >= 3) ? 1'b1 : 1'b0);
    end

    // Write with three wait states, read queued behind it
    tick();
    drive_cmd(1'b1, 32'h40, 1'b1, 3'd2, 32'h55);
    push_exp(32'h0, 1'b0);
    tick();
    drive_cmd(1'b1, 32'h44, 1'b0, 3'd2, 32'h0);
    push_exp(32'h77, 1'b0);
    #1;
    chk("ws_htrans_wr", HTRANS, 2'b10);
    chk("ws_haddr_wr", HADDR, 32'h40);
    for (int w = 0; w < 3; w++) begin
      tick();
      drive_cmd(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
      HREADY = 1'b0;
      #1;
      chk("ws_haddr_hold", HADDR, 32'h44);
      chk("ws_htrans_hold", HTRANS, 2'b10);
      chk("ws_hwdata_hold", HWDATA, 32'h55);
      chk("ws_cmd_ready", cmd_ready, 1'b0);
      chk("ws_rsp_valid", rsp_valid, 1'b0);
    end
    tick();
    HREADY = 1'b1;
    #1;
    chk("ws_haddr_rel", HADDR, 32'h44);
    chk("ws_hwdata_rel", HWDATA, 32'h55);
    chk("ws_cmd_ready_rel", cmd_ready, 1'b1);
    tick();
    HRDATA = 32'h77;
    #1;
    chk("ws_rsp_wr", rsp_valid, 1'b1);
    chk("ws_htrans_idle", HTRANS, 2'b00);
    tick();
    #1 chk("ws_rsp_rd", rsp_valid, 1'b1);

    // Two-cycle ERROR then SPLIT, each with a queued read that must be reissued once
    for (int t = 0; t < 2; t++) begin
      er = (t == 0) ? 2'b01 : 2'b11;
      tick();
      drive_cmd(1'b1, 32'hF000_0000, (t == 0), 3'd2, 32'hAA);
      push_exp((t == 0) ? 32'h0 : 32'hBAD0_0000, 1'b1);
      tick();
      drive_cmd(1'b1, 32'h100, 1'b0, 3'd2, 32'h0);
      push_exp(32'h1234 + 32'(t), 1'b0);
      #1;
      chk("err_htrans_bad", HTRANS, 2'b10);
      chk("err_haddr_bad", HADDR, 32'hF000_0000);
      tick();
      drive_cmd(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
      HREADY = 1'b0;
      HRESP  = er;
      #1;
      chk("err1_htrans", HTRANS, 2'b10);
      chk("err1_haddr", HADDR, 32'h100);
      chk("err1_cmd_ready", cmd_ready, 1'b0);
      tick();
      HREADY = 1'b1;
      HRDATA = 32'hBAD0_0000;
      #1;
      chk("err2_htrans", HTRANS, 2'b00);
      chk("err2_cmd_ready", cmd_ready, 1'b0);
      tick();
      HRESP = 2'b00;
      #1;
      chk("err_rsp_valid", rsp_valid, 1'b1);
      chk("reissue_htrans", HTRANS, 2'b10);
      chk("reissue_haddr", HADDR, 32'h100);
      tick();
      HRDATA = 32'h1234 + 32'(t);
      #1 chk("reissue_once", HTRANS, 2'b00);
      tick();
      #1 chk("reissue_rsp", rsp_valid, 1'b1);
    end

    // Reset during a stalled write; the in-flight command must vanish
    tick();
    drive_cmd(1'b1, 32'h300, 1'b1, 3'd2, 32'h99);
    tick();
    drive_cmd(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    #1 chk("rst_mid_htrans_pre", HTRANS, 2'b10);
    tick();
    HREADY = 1'b0;
    #1 chk("rst_mid_hwdata_pre", HWDATA, 32'h99);
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_mid_htrans", HTRANS, 2'b00);
    chk("rst_mid_hwdata", HWDATA, 32'h0);
    chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
    chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
    tick();
    tick();
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    drive_cmd(1'b1, 32'h400, 1'b0, 3'd2, 32'h0);
    push_exp(32'h4444, 1'b0);
    #1 chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    tick();
    drive_cmd(1'b0, 32'h0, 1'b0, 3'd0, 32'h0);
    #1;
    chk("post_rst_htrans", HTRANS, 2'b10);
    chk("post_rst_haddr", HADDR, 32'h400);
    tick();
    HRDATA = 32'h4444;
    tick();
    #1 chk("post_rst_rsp", rsp_valid, 1'b1);

    tick();
    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_lite_cmd_master.md
# ahb_lite_cmd_master

Single-transfer AHB-Lite initiator that turns a simple command/response interface into pipelined NONSEQ/SINGLE AHB transfers. It is the master-side counterpart of the slaves on the L1 matrix, including the default slave, and drives one matrix slave port. Its job is to complete every command on the bus, honour HREADY wait states, and handle the two-cycle ERROR response. Typical users are DMA-lite engines, debug bridges and boot loaders.

## Interface
- ADDR_WIDTH, 32, HADDR and cmd_addr width
- DATA_WIDTH, 32, HWDATA/HRDATA and command/response data width
- HPROT_VAL, 4'b0011, constant driven on HPROT (non-cacheable, non-bufferable, privileged, data)
- HCLK  in  1  AHB clock; all logic is on its rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on an edge where cmd_valid & cmd_ready
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  3  HSIZE value, 0..2 only
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse per completed transfer; no backpressure
- rsp_rdata  out  DATA_WIDTH  HRDATA captured at completion (reads); 0 for writes
- rsp_error  out  1  transfer completed with a non-OKAY response
- HADDR  out  ADDR_WIDTH; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  3 (always 3'b000); HPROT  out  4 (HPROT_VAL); HWDATA  out  DATA_WIDTH
- HREADY  in  1  bus ready (matrix-returned HREADYOUT)
- HRESP  in  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
- HRDATA  in  DATA_WIDTH  read data

## Operation
- Two pipeline stages: an address-phase register (ap_valid, addr, write, size, wdata, htrans_q) and a data-phase register (dp_valid, write, wdata).
- cmd_ready = ~ap_valid | (HREADY & htrans_q==NONSEQ & ~err1). This is combinational on HREADY.
- On an accepted command, ap loads the command and htrans_q <= NONSEQ. HADDR, HWRITE and HSIZE are driven from ap. HTRANS = ap_valid ? htrans_q : IDLE.
- At an edge with HREADY=1 and HTRANS=NONSEQ:
  - ap moves to dp (dp_valid=1).
  - ap is cleared unless a new command is accepted on the same edge.
- At an edge with HREADY=1 and dp_valid=1, the data phase completes:
  - rsp_valid <= 1, rsp_error <= (HRESP!=00).
  - rsp_rdata <= dp_write ? 0 : HRDATA.
  - dp_valid is cleared unless ap advances on the same edge.
- HWDATA = dp_wdata while dp_valid, else 0. HWDATA is held stable through wait states.
- err1 (first ERROR cycle) = dp_valid & ~HREADY & HRESP!=00.
  - On that edge htrans_q <= IDLE. The pending ap command is retained, not dropped.
  - HTRANS is therefore IDLE during the second error cycle.
- On the edge ending the second error cycle (HREADY=1), if ap_valid and htrans_q==IDLE, then htrans_q <= NONSEQ. The retained command is reissued as NONSEQ in the following cycle.
- RETRY/SPLIT are handled identically to ERROR (no re-request); rsp_error=1.
- Non-OKAY with HREADY=1 and no preceding wait cycle (protocol violation): the transfer still completes with rsp_error=1, and no cancellation occurs.
- A cmd_size > 2 is forwarded unchanged; this is illegal stimulus and is not checked.

## Timing
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, HBURST=000, HPROT=HPROT_VAL, rsp_valid=0, rsp_rdata=0, rsp_error=0, cmd_ready=1, ap_valid=0, dp_valid=0, htrans_q=IDLE.
- Latency with a zero-wait slave:
  - Command accepted at edge E.
  - NONSEQ on the bus in cycle E+1.
  - Data phase in cycle E+2.
  - rsp_valid high in cycle E+3.
- Each slave wait state adds one cycle.
- Throughput is one transfer per cycle with back-to-back cmd_valid and a zero-wait slave.
- ERROR sequence: wait/ERROR cycle, then ready/ERROR cycle with HTRANS IDLE. The retained command reappears as NONSEQ one cycle after the error completes (two-cycle bubble).
- Reset asserted mid-transfer: all state clears immediately and asynchronously, and no rsp_valid is produced for in-flight commands. Both sides of the bus are expected to be reset together.
- HRESP and HRDATA are sampled only on edges where HREADY=1 (completion) or where err1 applies.

## Test plan
- Read, zero-wait slave. cmd addr=0x2000_0010, write=0, size=2; HRDATA=0xCAFE_F00D -> HTRANS=10 one cycle after accept; rsp_valid exactly 3 cycles after accept, rsp_rdata=0xCAFE_F00D, rsp_error=0.
- Four back-to-back writes (0x0,0x4,0x8,0xC, data 1..4), zero-wait -> HTRANS=10 for 4 consecutive cycles; HWDATA=1..4 each one cycle after its address; 4 consecutive rsp_valid pulses.
- Write with 3 wait states plus a following read queued -> HADDR/HWDATA held during all wait cycles; the second NONSEQ is held with the same HADDR until HREADY=1; cmd_ready=0 while stalled.
- Unmapped address (default slave), followed by a queued read to 0x100 -> cycle 1: HREADY=0, HRESP=01, then HTRANS=00; cycle 2: HREADY=1, HRESP=01. rsp_error=1. The next cycle shows HTRANS=10 with HADDR=0x100, and the read later completes with rsp_error=0.
- HRESETn asserted while a transfer waits with HREADY=0 -> HTRANS=00, HWDATA=0, rsp_valid=0 immediately; after release, cmd_ready=1 and a new read completes normally.
- HRESP=11 (SPLIT) two-cycle response -> treated as ERROR: rsp_error=1 and the pending command is reissued exactly once.
